// File: rtl/el2_noc_join_endpoint.sv
// el2_noc_join_endpoint: joins one operand packet from every NoC input channel for a functional unit and sends its results back out as a header flit followed by data flits
//   clk, rst_l          : clock, asynchronous active-low reset
//   flush               : synchronous abort of everything in flight
//   in_valid/in_data/in_ready    : per-channel operand flit ports (channel i at [i*FLIT_W +: FLIT_W])
//   op_valid/op_data/op_ready    : joined operands to the functional unit (channel i at [i*PKT_W +: PKT_W])
//   res_valid/res_data/res_ready : result from the functional unit
//   out_valid/out_data/out_head/out_ready : result flits towards the NoC
module el2_noc_join_endpoint #(
   parameter int                NUM_CH   = 2,
   parameter int                FLIT_W   = 8,
   parameter int                PKT_W    = 32,
   parameter int                RES_W    = 32,
   parameter int                ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] DST_ADDR = 4'h3
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*FLIT_W-1:0] in_data,
   output logic [NUM_CH-1:0]        in_ready,
   output logic                     op_valid,
   output logic [NUM_CH*PKT_W-1:0]  op_data,
   input  logic                     op_ready,
   input  logic                     res_valid,
   input  logic [RES_W-1:0]         res_data,
   output logic                     res_ready,
   output logic                     out_valid,
   output logic [FLIT_W-1:0]        out_data,
   output logic                     out_head,
   input  logic                     out_ready
);
   localparam int FLITS     = (PKT_W + FLIT_W - 1) / FLIT_W;
   localparam int RES_FLITS = (RES_W + FLIT_W - 1) / FLIT_W;
   localparam int CNT_W     = FLITS > 1 ? $clog2(FLITS) : 1;
   localparam int IDX_W     = RES_FLITS > 1 ? $clog2(RES_FLITS) : 1;
   localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RES_FLITS - 1);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] done;
   logic              consume;

   assign consume  = op_valid && op_ready;
   assign in_ready = ~full & {NUM_CH{!flush}};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             full_r;
      logic [PKT_W-1:0] pkt;
      logic             acc;
      assign acc     = in_valid[i] && in_ready[i];
      assign done[i] = acc && cnt == LAST_FLIT;
      assign full[i] = full_r;
      assign op_data[i*PKT_W +: PKT_W] = pkt;
      // The packet register doubles as op_data; it is frozen while full because in_ready is low.
      always_ff @(posedge clk or negedge rst_l)
         if (!rst_l) begin
            cnt    <= '0;
            full_r <= 1'b0;
            pkt    <= '0;
         end else if (flush) begin
            cnt    <= '0;
            full_r <= 1'b0;
         end else if (consume) begin
            full_r <= 1'b0;
         end else if (acc) begin
            cnt    <= done[i] ? '0 : cnt + 1'b1;
            full_r <= done[i];
            // Bit-wise write so that flit bits beyond PKT_W in the last flit are simply dropped.
            for (int b = 0; b < PKT_W; b++)
               if (cnt == CNT_W'(b / FLIT_W)) pkt[b] <= in_data[i*FLIT_W + b%FLIT_W];
         end
   end

   // Registered copy of "all full next cycle", so it rises one cycle after the last missing flit.
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) op_valid <= 1'b0;
      else        op_valid <= !flush && !consume && &(full | done);

   typedef enum logic [1:0] {IDLE, HEAD, DATA} state_t;

   state_t                       state, state_nxt;
   logic [IDX_W-1:0]             idx, idx_nxt;
   logic [RES_FLITS*FLIT_W-1:0]  rbuf, rbuf_nxt;
   logic [FLIT_W-1:0]            hdr;

   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) begin
         state <= IDLE;
         idx   <= '0;
         rbuf  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         rbuf  <= rbuf_nxt;
      end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rbuf_nxt  = rbuf;
      hdr       = '0;
      hdr[ADDR_W-1:0] = DST_ADDR;
      res_ready = 1'b0;
      out_valid = 1'b0;
      out_head  = 1'b0;
      out_data  = '0;
      if (flush) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         rbuf_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               res_ready = 1'b1;
               if (res_valid) begin
                  rbuf_nxt = '0;
                  rbuf_nxt[RES_W-1:0] = res_data;
                  state_nxt = HEAD;
               end
            end
            HEAD: begin
               out_valid = 1'b1;
               out_head  = 1'b1;
               out_data  = hdr;
               if (out_ready) begin
                  state_nxt = DATA;
                  idx_nxt   = '0;
               end
            end
            DATA: begin
               out_valid = 1'b1;
               out_data  = rbuf[int'(idx)*FLIT_W +: FLIT_W];
               if (out_ready) begin
                  idx_nxt   = idx == LAST_IDX ? '0 : idx + 1'b1;
                  state_nxt = idx == LAST_IDX ? IDLE : DATA;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_el2_noc_join_endpoint.sv
// tb_el2_noc_join_endpoint: self-checking bench for el2_noc_join_endpoint with default parameters
module tb_el2_noc_join_endpoint;
   logic        clk = 1'b0;
   logic        rst_l, flush, op_ready, res_valid, out_ready;
   logic [1:0]  in_valid, in_ready;
   logic [15:0] in_data;
   logic        op_valid, res_ready, out_valid, out_head;
   logic [63:0] op_data;
   logic [31:0] res_data;
   logic [7:0]  out_data;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   el2_noc_join_endpoint dut (
      .clk(clk), .rst_l(rst_l), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .out_valid(out_valid), .out_data(out_data), .out_head(out_head), .out_ready(out_ready)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } jvec_t;

   typedef struct {
      logic        rv;
      logic [31:0] rd;
      logic        ordy;
      logic        ev;
      logic        eh;
      logic [7:0]  ed;
      logic        err;
   } svec_t;

   jvec_t       jt[3];
   svec_t       st[18];
   logic [7:0]  rx0[$];
   logic [7:0]  rx1[$];
   logic [8:0]  txq[$];
   logic        e_op, e_ov, e_rr;
   logic [1:0]  e_ir;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic do_join(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         in_valid = 2'b11;
         in_data  = {b[k*8 +: 8], a[k*8 +: 8]};
         @(negedge clk);
         chk("join_in_ready", in_ready, 2'b11);
         chk("join_op_valid_early", op_valid, 1'b0);
      end
      @(posedge clk); #1;
      in_valid = 2'b00;
      @(negedge clk);
      chk("join_op_valid", op_valid, 1'b1);
      chk("join_op_data", op_data, exp);
   endtask

   initial begin
      jt[0] = '{32'h11223344, 32'hAABBCCDD, 64'hAABBCCDD_11223344};
      jt[1] = '{32'h00000000, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000};
      jt[2] = '{32'h12345678, 32'h9ABCDEF0, 64'h9ABCDEF0_12345678};
      st[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      st[1]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
      st[2]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'hEF, 1'b0};
      st[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'hBE, 1'b0};
      st[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'hAD, 1'b0};
      st[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'hDE, 1'b0};
      st[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      st[7]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      st[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0};
      st[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
      st[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
      st[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0};
      st[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0};
      st[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0};
      st[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0};
      st[15] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0};
      st[16] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0};
      st[17] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

      rst_l = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; op_ready = 1'b1;
      res_valid = 1'b0; res_data = '0; out_ready = 1'b0;
      @(posedge clk); #2;
      chk("rst_op_valid", op_valid, 1'b0);
      chk("rst_op_data", op_data, 64'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_head", out_head, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_in_ready", in_ready, 2'b11);
      chk("rst_res_ready", res_ready, 1'b1);
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 2'b11);
      chk("post_rst_res_ready", res_ready, 1'b1);

      for (int j = 0; j < 3; j++) begin
         do_join(jt[j].a, jt[j].b, jt[j].exp);
         @(posedge clk); #1;
         @(negedge clk);
         chk("join_drop", op_valid, 1'b0);
         chk("join_ready_back", in_ready, 2'b11);
      end

      op_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         in_valid = 2'b01;
         in_data  = {8'h00, 8'h3C - 8'(k * 8'h0F)};
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         in_valid = 2'b01;
         in_data  = 16'h00EE;
         @(negedge clk);
         chk("ch0_full_in_ready", in_ready, 2'b10);
         chk("ch0_full_op_valid", op_valid, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         in_valid = 2'b11;
         in_data  = {8'h78 - 8'(k * 8'h0F), 8'hEE};
      end
      @(posedge clk); #1;
      in_valid = 2'b00;
      @(negedge clk);
      chk("late_join_op_valid", op_valid, 1'b1);
      chk("late_join_op_data", op_data, 64'h4B5A6978_0F1E2D3C);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_op_valid", op_valid, 1'b1);
         chk("hold_op_data", op_data, 64'h4B5A6978_0F1E2D3C);
         chk("hold_in_ready", in_ready, 2'b00);
      end
      @(posedge clk); #1;
      op_ready = 1'b1;
      @(negedge clk);
      chk("release_op_valid", op_valid, 1'b1);
      @(posedge clk); #1;
      op_ready = 1'b0;
      @(negedge clk);
      chk("release_in_ready", in_ready, 2'b11);
      chk("release_op_valid_low", op_valid, 1'b0);
      op_ready = 1'b1;

      for (int k = 0; k < 18; k++) begin
         @(posedge clk); #1;
         res_valid = st[k].rv;
         res_data  = st[k].rd;
         out_ready = st[k].ordy;
         @(negedge clk);
         chk("send_out_valid", out_valid, st[k].ev);
         chk("send_out_head", out_head, st[k].eh);
         chk("send_out_data", out_data, st[k].ed);
         chk("send_res_ready", res_ready, st[k].err);
      end

      @(posedge clk); #1;
      res_valid = 1'b1; res_data = 32'h12345678; out_ready = 1'b0;
      @(posedge clk); #1;
      res_valid = 1'b0; in_valid = 2'b01; in_data = 16'h0055;
      @(negedge clk);
      chk("flush_pre_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      in_data = 16'h0066;
      @(posedge clk); #1;
      flush = 1'b1; in_data = 16'h0077; res_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 2'b00);
      chk("flush_res_ready", res_ready, 1'b0);
      chk("flush_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 2'b00; res_valid = 1'b0;
      @(negedge clk);
      chk("after_flush_out_valid", out_valid, 1'b0);
      chk("after_flush_in_ready", in_ready, 2'b11);
      chk("after_flush_res_ready", res_ready, 1'b1);
      chk("after_flush_op_valid", op_valid, 1'b0);
      do_join(32'hCAFEF00D, 32'h0BADBEEF, 64'h0BADBEEF_CAFEF00D);
      @(posedge clk); #1;

      res_valid = 1'b1; res_data = 32'h0; out_ready = 1'b0; in_valid = 2'b11; in_data = 16'h1234;
      @(posedge clk); #1;
      res_valid = 1'b0; in_valid = 2'b01;
      @(negedge clk); #2;
      rst_l = 1'b0;
      #1;
      chk("mid_rst_op_valid", op_valid, 1'b0);
      chk("mid_rst_op_data", op_data, 64'h0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_head", out_head, 1'b0);
      chk("mid_rst_out_data", out_data, 8'h00);
      chk("mid_rst_in_ready", in_ready, 2'b11);
      chk("mid_rst_res_ready", res_ready, 1'b1);
      @(negedge clk);
      rst_l = 1'b1; in_valid = 2'b00; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("post_mid_rst_out_valid", out_valid, 1'b0);
      end
      do_join(jt[2].a, jt[2].b, jt[2].exp);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_mid_rst_drop", op_valid, 1'b0);

      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = 2'($urandom);
         in_data   = 16'($urandom);
         op_ready  = ($urandom_range(0, 2) != 0);
         res_valid = ($urandom_range(0, 3) == 0);
         res_data  = $urandom;
         out_ready = 1'($urandom);
         @(negedge clk);
         e_op = rx0.size() == 4 && rx1.size() == 4;
         e_ir = {rx1.size() < 4 && !flush, rx0.size() < 4 && !flush};
         e_rr = txq.size() == 0 && !flush;
         e_ov = txq.size() != 0 && !flush;
         chk("rnd_in_ready", in_ready, e_ir);
         chk("rnd_op_valid", op_valid, e_op);
         chk("rnd_res_ready", res_ready, e_rr);
         chk("rnd_out_valid", out_valid, e_ov);
         if (e_op)
            chk("rnd_op_data", op_data, {rx1[3], rx1[2], rx1[1], rx1[0], rx0[3], rx0[2], rx0[1], rx0[0]});
         if (e_ov)
            chk("rnd_out_flit", {out_head, out_data}, txq[0]);
         if (flush) begin
            rx0.delete();
            rx1.delete();
            txq.delete();
         end else begin
            if (e_op && op_ready) begin
               rx0.delete();
               rx1.delete();
            end else begin
               if (in_valid[0] && e_ir[0]) rx0.push_back(in_data[7:0]);
               if (in_valid[1] && e_ir[1]) rx1.push_back(in_data[15:8]);
            end
            if (e_ov && out_ready) void'(txq.pop_front());
            else if (e_rr && res_valid) begin
               txq.push_back({1'b1, 8'h03});
               for (int k = 0; k < 4; k++) txq.push_back({1'b0, res_data[k*8 +: 8]});
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
